// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer.
// State enum, opcode constants, result width and FIFO entry type.
package alu_seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam int RES_W = 4;

  typedef struct packed {
    logic [1:0]       sel;
    logic [RES_W-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/Two_bit_ALU.sv
// Combinational 2-bit ALU driven by the sequencer.
// Ports: x1,x0,y1,y0 operands, sel1,sel0 opcode, out3..out0 result.
module Two_bit_ALU
  import alu_seq_pkg::*;
(
  input  logic x1,
  input  logic x0,
  input  logic y1,
  input  logic y0,
  input  logic sel1,
  input  logic sel0,
  output logic out3,
  output logic out2,
  output logic out1,
  output logic out0
);

  logic [1:0] x;
  logic [1:0] y;
  logic [1:0] sel;
  logic [2:0] d;
  logic [3:0] r;

  assign x   = {x1, x0};
  assign y   = {y1, y0};
  assign sel = {sel1, sel0};
  // {borrow, 2-bit difference}
  assign d   = {1'b0, x} - {1'b0, y};

  always_comb begin
    r = '0;
    unique case (sel)
      OP_ZERO: r = '0;
      OP_ADD:  r = {2'b00, x} + {2'b00, y};
      OP_SUB:  r = {1'b0, d};
      OP_MUL:  r = {2'b00, x} * {2'b00, y};
    endcase
  end

  assign {out3, out2, out1, out0} = r;

endmodule

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO, DEPTH a power of two >= 2.
// Ports: push/wdata in, pop in, rdata head out, full/empty/count status.
module alu_res_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  res_entry_t               wdata,
  input  logic                     pop,
  output res_entry_t               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  res_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Empty head reads as zero so no stale entry is ever visible.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 2-bit ALU: registered operands, settle, result FIFO.
// Ports: cmd_* handshake in, alu_* to ALU, alu_out* back, res_* handshake out;
// res_count (pop counter, saturating) exists only with ALU_SEQ_COUNT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int RES_DEPTH     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_x,
  input  logic [1:0] cmd_y,
  input  logic [1:0] cmd_sel,
  output logic       alu_x1,
  output logic       alu_x0,
  output logic       alu_y1,
  output logic       alu_y0,
  output logic       alu_sel1,
  output logic       alu_sel0,
  input  logic       alu_out3,
  input  logic       alu_out2,
  input  logic       alu_out1,
  input  logic       alu_out0,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_sel
`ifdef ALU_SEQ_COUNT_EN
  ,
  output logic [7:0] res_count
`endif
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(RES_DEPTH);
  localparam logic [3:0]  LAST    = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [1:0] x_q;
  logic [1:0] y_q;
  logic [1:0] sel_q;
  logic       accept;
  logic       settle_done;
  logic       push;
  logic       pop;
  res_entry_t wr_entry;
  res_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [AW:0] fifo_count;

  // Held low through reset so nothing is taken while state is clearing.
  assign cmd_ready = !rst && (state == IDLE) && (fifo_count < DEPTH_C);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt   = state;
    settle_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == LAST) begin
          settle_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q        <= cmd_x;
        y_q        <= cmd_y;
        sel_q      <= cmd_sel;
        settle_cnt <= '0;
      end else if (state == SETTLE && !settle_done) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  assign {alu_x1, alu_x0}     = x_q;
  assign {alu_y1, alu_y0}     = y_q;
  assign {alu_sel1, alu_sel0} = sel_q;

  assign wr_entry.sel  = sel_q;
  assign wr_entry.data = {alu_out3, alu_out2, alu_out1, alu_out0};
  assign push          = settle_done && !fifo_full;
  assign pop           = res_valid && res_ready;

  alu_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = head.data;
  assign res_sel   = head.sel;

`ifdef ALU_SEQ_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      res_count <= '0;
    end else if (pop && res_count != 8'hFF) begin
      res_count <= res_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: SETTLE=1 and SETTLE=3 sequencers, each with a Two_bit_ALU.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic       c1_valid, c1_ready, r1_ready, r1_valid;
  logic [1:0] c1_x, c1_y, c1_s, r1_sel;
  logic [3:0] r1_data;
  wire  [1:0] a1_x, a1_y, a1_s;
  wire  [3:0] o1;
  logic [7:0] cnt1;

  logic       c3_valid, c3_ready, r3_ready, r3_valid;
  logic [1:0] c3_x, c3_y, c3_s, r3_sel;
  logic [3:0] r3_data;
  wire  [1:0] a3_x, a3_y, a3_s;
  wire  [3:0] m3;
  wire  [3:0] o3;
  logic       ovr_en;
  logic [3:0] ovr;
  logic [7:0] cnt3;

  assign o3 = ovr_en ? ovr : m3;

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .RES_DEPTH(2)) u1 (
    .clk(clk), .rst(rst),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_x(c1_x), .cmd_y(c1_y), .cmd_sel(c1_s),
    .alu_x1(a1_x[1]), .alu_x0(a1_x[0]),
    .alu_y1(a1_y[1]), .alu_y0(a1_y[0]),
    .alu_sel1(a1_s[1]), .alu_sel0(a1_s[0]),
    .alu_out3(o1[3]), .alu_out2(o1[2]),
    .alu_out1(o1[1]), .alu_out0(o1[0]),
    .res_valid(r1_valid), .res_ready(r1_ready),
    .res_data(r1_data), .res_sel(r1_sel)
`ifdef ALU_SEQ_COUNT_EN
    , .res_count(cnt1)
`endif
  );

  Two_bit_ALU m_alu1 (
    .x1(a1_x[1]), .x0(a1_x[0]), .y1(a1_y[1]), .y0(a1_y[0]),
    .sel1(a1_s[1]), .sel0(a1_s[0]),
    .out3(o1[3]), .out2(o1[2]), .out1(o1[1]), .out0(o1[0])
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(3), .RES_DEPTH(2)) u3 (
    .clk(clk), .rst(rst),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_x(c3_x), .cmd_y(c3_y), .cmd_sel(c3_s),
    .alu_x1(a3_x[1]), .alu_x0(a3_x[0]),
    .alu_y1(a3_y[1]), .alu_y0(a3_y[0]),
    .alu_sel1(a3_s[1]), .alu_sel0(a3_s[0]),
    .alu_out3(o3[3]), .alu_out2(o3[2]),
    .alu_out1(o3[1]), .alu_out0(o3[0]),
    .res_valid(r3_valid), .res_ready(r3_ready),
    .res_data(r3_data), .res_sel(r3_sel)
`ifdef ALU_SEQ_COUNT_EN
    , .res_count(cnt3)
`endif
  );

  Two_bit_ALU m_alu3 (
    .x1(a3_x[1]), .x0(a3_x[0]), .y1(a3_y[1]), .y0(a3_y[0]),
    .sel1(a3_s[1]), .sel0(a3_s[0]),
    .out3(m3[3]), .out2(m3[2]), .out1(m3[1]), .out0(m3[0])
  );

`ifndef ALU_SEQ_COUNT_EN
  assign cnt1 = 8'd0;
  assign cnt3 = 8'd0;
`endif

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] s;
    logic [3:0] d;
  } vec_t;

  vec_t tv [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send1(input logic [1:0] x, input logic [1:0] y,
                       input logic [1:0] s);
    bit ok = 1'b0;
    c1_x = x; c1_y = y; c1_s = s; c1_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (c1_ready === 1'b1) ok = 1'b1;
      step();
    end
    c1_valid = 1'b0;
    if (!ok) chk("send1_timeout", 8'd0, 8'd1);
  endtask

  task automatic send3(input logic [1:0] x, input logic [1:0] y,
                       input logic [1:0] s);
    bit ok = 1'b0;
    c3_x = x; c3_y = y; c3_s = s; c3_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (c3_ready === 1'b1) ok = 1'b1;
      step();
    end
    c3_valid = 1'b0;
    if (!ok) chk("send3_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{2'd3, 2'd2, 2'b01, 4'b0101};
    tv[1] = '{2'd1, 2'd2, 2'b10, 4'b0111};
    tv[2] = '{2'd3, 2'd3, 2'b11, 4'b1001};
    tv[3] = '{2'd3, 2'd1, 2'b00, 4'b0000};
    tv[4] = '{2'd3, 2'd3, 2'b01, 4'b0110};
    tv[5] = '{2'd3, 2'd1, 2'b10, 4'b0010};
    tv[6] = '{2'd0, 2'd3, 2'b10, 4'b0101};
    tv[7] = '{2'd2, 2'd3, 2'b11, 4'b0110};
    tv[8] = '{2'd0, 2'd0, 2'b01, 4'b0000};

    rst = 1'b1;
    c1_valid = 0; c1_x = 0; c1_y = 0; c1_s = 0; r1_ready = 0;
    c3_valid = 0; c3_x = 0; c3_y = 0; c3_s = 0; r3_ready = 0;
    ovr_en = 0; ovr = 0;
    c1_valid = 1'b1;
    repeat (3) step();

    chk("rst_cmd_ready", 8'(c1_ready), 8'd0);
    chk("rst_res_valid", 8'(r1_valid), 8'd0);
    chk("rst_res_data", 8'(r1_data), 8'd0);
    chk("rst_res_sel", 8'(r1_sel), 8'd0);
    chk("rst_alu", 8'({a1_x, a1_y, a1_s}), 8'd0);
    chk("rst_count", cnt1, 8'd0);
    c1_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 8'(c1_ready), 8'd1);
    step();

    for (int i = 0; i < 9; i++) begin
      send1(tv[i].x, tv[i].y, tv[i].s);
      chk($sformatf("v%0d_early", i), 8'(r1_valid), 8'd0);
      chk($sformatf("v%0d_alu", i), 8'({a1_x, a1_y, a1_s}),
          8'({tv[i].x, tv[i].y, tv[i].s}));
      step();
      chk($sformatf("v%0d_valid", i), 8'(r1_valid), 8'd1);
      chk($sformatf("v%0d_data", i), 8'(r1_data), 8'(tv[i].d));
      chk($sformatf("v%0d_sel", i), 8'(r1_sel), 8'(tv[i].s));
      r1_ready = 1'b1;
      step();
      r1_ready = 1'b0;
      chk($sformatf("v%0d_drain", i), 8'(r1_valid), 8'd0);
    end

    // Backpressure: two fill the FIFO, third waits.
    send1(2'd1, 2'd1, 2'b01);
    step();
    send1(2'd2, 2'd2, 2'b11);
    step();
    c1_x = 2'd2; c1_y = 2'd1; c1_s = 2'b10; c1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 8'(c1_ready), 8'd0);
      chk("bp_head_hold", 8'(r1_data), 8'h02);
      step();
    end
    r1_ready = 1'b1;
    step();
    chk("bp_pop2_data", 8'(r1_data), 8'h04);
    chk("bp_pop2_sel", 8'(r1_sel), 8'h03);
    chk("bp_ready_back", 8'(c1_ready), 8'd1);
    step();
    c1_valid = 1'b0;
    chk("bp_empty", 8'(r1_valid), 8'd0);
    step();
    chk("bp_c_valid", 8'(r1_valid), 8'd1);
    chk("bp_c_data", 8'(r1_data), 8'h01);
    chk("bp_c_sel", 8'(r1_sel), 8'h02);
    step();
    r1_ready = 1'b0;
    chk("bp_drained", 8'(r1_valid), 8'd0);

    // SETTLE_CYCLES=3: only the final settle edge is captured.
    send3(2'd3, 2'd2, 2'b01);
    c3_x = 2'd0; c3_y = 2'd1; c3_s = 2'b11;
    ovr_en = 1'b1;
    ovr = 4'b1111;
    chk("s3_alu_a", 8'({a3_x, a3_y, a3_s}), 8'b00111001);
    chk("s3_early_a", 8'(r3_valid), 8'd0);
    step();
    ovr = 4'b1010;
    chk("s3_alu_b", 8'({a3_x, a3_y, a3_s}), 8'b00111001);
    chk("s3_early_b", 8'(r3_valid), 8'd0);
    step();
    ovr = 4'b0011;
    chk("s3_alu_c", 8'({a3_x, a3_y, a3_s}), 8'b00111001);
    chk("s3_early_c", 8'(r3_valid), 8'd0);
    step();
    ovr_en = 1'b0;
    chk("s3_valid", 8'(r3_valid), 8'd1);
    chk("s3_data", 8'(r3_data), 8'h03);
    chk("s3_sel", 8'(r3_sel), 8'h01);
    chk("s3_alu_kept", 8'({a3_x, a3_y, a3_s}), 8'b00111001);
    r3_ready = 1'b1;
    step();
    r3_ready = 1'b0;
    send3(2'd3, 2'd2, 2'b11);
    step();
    step();
    chk("s3_mul_early", 8'(r3_valid), 8'd0);
    step();
    chk("s3_mul_valid", 8'(r3_valid), 8'd1);
    chk("s3_mul_data", 8'(r3_data), 8'h06);
    r3_ready = 1'b1;
    step();
    r3_ready = 1'b0;

    // Reset during SETTLE with one queued result.
    send1(2'd1, 2'd2, 2'b01);
    step();
    chk("rm_queued", 8'(r1_valid), 8'd1);
    send1(2'd3, 2'd3, 2'b11);
    rst = 1'b1;
    step();
    chk("rm_valid_in_rst", 8'(r1_valid), 8'd0);
    chk("rm_ready_in_rst", 8'(c1_ready), 8'd0);
    rst = 1'b0;
    step();
    chk("rm_valid_after", 8'(r1_valid), 8'd0);
    chk("rm_alu_after", 8'({a1_x, a1_y, a1_s}), 8'd0);
    chk("rm_data_after", 8'(r1_data), 8'd0);
    repeat (3) step();
    chk("rm_no_stale", 8'(r1_valid), 8'd0);
    chk("rm_ready_idle", 8'(c1_ready), 8'd1);

`ifdef ALU_SEQ_COUNT_EN
    begin
      int  pops = 0;
      bit  held = 1'b0;
      int  cyc = 0;
      chk("cnt_after_rst", cnt1, 8'd0);
      c1_x = 2'd1; c1_y = 2'd1; c1_s = 2'b01; c1_valid = 1'b1;
      r1_ready = 1'b1;
      while (pops < 300 && cyc < 3000) begin
        if (r1_valid && r1_ready) pops++;
        step();
        cyc++;
        if (pops == 100 && !held) begin
          chk("cnt_100", cnt1, 8'd100);
          r1_ready = 1'b0;
          repeat (6) step();
          chk("cnt_hold", cnt1, 8'd100);
          r1_ready = 1'b1;
          held = 1'b1;
        end
      end
      if (pops < 300) chk("cnt_timeout", 8'd0, 8'd1);
      c1_valid = 1'b0;
      r1_ready = 1'b0;
      chk("cnt_sat", cnt1, 8'd255);
      repeat (4) step();
      chk("cnt_sat_hold", cnt1, 8'd255);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
